// File: rtl/network_mac_seq_16s_14s.sv
// Dot-product sequencer for the shared 16s x 14s multiplier (2-cycle latency).
// Define NETWORK_MAC_SAT_EN to saturate out_data; otherwise it wraps.
module network_mac_seq_16s_14s #(
    parameter int LEN_WIDTH = 8,
    parameter int ACC_WIDTH = 38,
    parameter int SHIFT     = 13
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] len,
    output logic                 busy,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [15:0]          in_a,
    input  logic [13:0]          in_b,
    output logic                 mul_ce,
    output logic [15:0]          mul_din0,
    output logic [13:0]          mul_din1,
    input  logic [29:0]          mul_dout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [15:0]          out_data,
    output logic                 out_ovf
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                       state_q, state_d;
    logic [LEN_WIDTH-1:0]         len_q, len_d;
    logic [LEN_WIDTH-1:0]         cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0]         cnt_inc;
    logic [1:0]                   v_q, v_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic signed [ACC_WIDTH-1:0]  prod_ext;
    logic signed [ACC_WIDTH-1:0]  s;
    logic [ACC_WIDTH-16:0]        s_hi;
    logic                         hs;
    logic                         ovf;
    logic [15:0]                  res;

    assign busy      = (state_q != S_IDLE);
    assign in_ready  = (state_q == S_RUN) && (cnt_q < len_q);
    assign hs        = in_valid && in_ready;
    assign mul_ce    = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign mul_din0  = hs ? in_a : 16'd0;
    assign mul_din1  = hs ? in_b : 14'd0;
    assign out_valid = (state_q == S_DONE);
    assign cnt_inc   = cnt_q + 1'b1;
    assign prod_ext  = {{(ACC_WIDTH-30){mul_dout[29]}}, mul_dout};

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        v_d     = v_q;
        acc_d   = acc_q;
        // Bubbles shift through too: the pipeline never stalls.
        if (mul_ce) begin
            v_d = {v_q[0], hs};
            if (v_q[1]) begin
                acc_d = acc_q + prod_ext;
            end
        end
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = len;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = (len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (hs) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Last product is added on this edge when stage 0 is empty.
                if (!v_q[0]) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            v_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            v_q     <= v_d;
            acc_q   <= acc_d;
        end
    end

    assign s    = acc_q >>> SHIFT;
    assign s_hi = s[ACC_WIDTH-1:15];
    assign ovf  = !((&s_hi) || !(|s_hi));

`ifdef NETWORK_MAC_SAT_EN
    always_comb begin
        res = s[15:0];
        if (ovf) begin
            res = s[ACC_WIDTH-1] ? 16'h8000 : 16'h7FFF;
        end
    end
`else
    assign res = s[15:0];
`endif

    assign out_data = out_valid ? res : 16'd0;
    assign out_ovf  = out_valid && ovf;

endmodule

// File: tb/tb_network_mac_seq_16s_14s.sv
// Directed self-checking bench for network_mac_seq_16s_14s.
// Includes a 2-stage behavioural model of the ce-gated multiplier.
module tb_network_mac_seq_16s_14s;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  len = 8'd0;
    logic        busy;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = 16'd0;
    logic [13:0] in_b = 14'd0;
    logic        mul_ce;
    logic [15:0] mul_din0;
    logic [13:0] mul_din1;
    logic [29:0] mul_dout;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_ovf;

    int total = 0;
    int bad = 0;

    logic signed [15:0] ta [0:7];
    logic signed [13:0] tw [0:7];
    logic               tv [0:15];
    int done_cyc, ce_cnt, hs_cnt, rdy_late;

    logic signed [29:0] m1 = 30'sd12345678;
    logic signed [29:0] m2 = -30'sd7654321;

    network_mac_seq_16s_14s dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1),
        .mul_dout(mul_dout), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mul_ce) begin
            m1 <= $signed(mul_din0) * $signed(mul_din1);
            m2 <= m1;
        end
    end
    assign mul_dout = m2;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic signed [15:0] a, input logic signed [13:0] b);
        for (int i = 0; i < 8; i++) begin
            ta[i] = a;
            tw[i] = b;
        end
        for (int i = 0; i < 16; i++) tv[i] = 1'b1;
    endtask

    // Starts a job at the current cycle (cycle 0) and runs until out_valid.
    task automatic run_job(input int n);
        start = 1'b1;
        len = n[7:0];
        in_valid = 1'b0;
        step;
        start = 1'b0;
        done_cyc = -1;
        ce_cnt = 0;
        hs_cnt = 0;
        rdy_late = 0;
        for (int c = 1; c <= 60; c++) begin
            in_valid = (c <= 16) ? tv[c-1] : 1'b1;
            in_a = ta[hs_cnt % 8];
            in_b = tw[hs_cnt % 8];
            @(negedge clk);
            if (mul_ce) ce_cnt++;
            if (hs_cnt >= n && in_ready) rdy_late++;
            if (in_valid && in_ready) hs_cnt++;
            if (out_valid) begin
                done_cyc = c;
                break;
            end
            step;
        end
        in_valid = 1'b0;
    endtask

    task automatic consume;
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step;
        step;
        total++;
        if ({busy, in_ready, mul_ce, out_valid, out_ovf} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b want=00000",
                     {busy, in_ready, mul_ce, out_valid, out_ovf});
        end
        total++;
        if ({mul_din0, mul_din1, out_data} !== 46'd0) begin
            bad++;
            $display("FAIL reset_data got=%h/%h/%h want=0/0/0",
                     mul_din0, mul_din1, out_data);
        end
        reset = 1'b0;
        step;
    endtask

    // 8192 is not representable in 14 signed bits, so -8192 scales by -1.
    task automatic test_basic;
        fill(-16'sd100, -14'sd8192);
        ta[1] = 16'sd200;
        ta[2] = -16'sd300;
        run_job(3);
        total++;
        if (done_cyc !== 6) begin
            bad++;
            $display("FAIL basic_latency got=%0d want=6", done_cyc);
        end
        total++;
        if (ce_cnt !== 5) begin
            bad++;
            $display("FAIL basic_ce_cycles got=%0d want=5", ce_cnt);
        end
        total++;
        if (out_data !== 16'd200 || out_ovf !== 1'b0) begin
            bad++;
            $display("FAIL basic_result got=%0d/%b want=200/0", $signed(out_data), out_ovf);
        end
        consume;
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_idle got=%b%b want=00", busy, out_valid);
        end
    endtask

    task automatic test_overflow;
        logic [15:0] exp_d;
`ifdef NETWORK_MAC_SAT_EN
        exp_d = 16'h7FFF;
`else
        exp_d = 16'hFFF6;
`endif
        fill(16'sd32767, 14'sd8191);
        run_job(2);
        total++;
        if (done_cyc !== 5) begin
            bad++;
            $display("FAIL ovf_latency got=%0d want=5", done_cyc);
        end
        total++;
        if (out_ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_flag got=%b want=1", out_ovf);
        end
        total++;
        if (out_data !== exp_d) begin
            bad++;
            $display("FAIL ovf_data got=%h want=%h", out_data, exp_d);
        end
        consume;
    endtask

    task automatic test_floor_and_zero;
        fill(-16'sd1, 14'sd1);
        run_job(1);
        total++;
        if (done_cyc !== 4 || out_data !== 16'hFFFF || out_ovf !== 1'b0) begin
            bad++;
            $display("FAIL floor_neg got=%0d/%h/%b want=4/ffff/0",
                     done_cyc, out_data, out_ovf);
        end
        consume;
        run_job(0);
        total++;
        if (done_cyc !== 1 || ce_cnt !== 0) begin
            bad++;
            $display("FAIL len0_timing got=%0d/%0d want=1/0", done_cyc, ce_cnt);
        end
        total++;
        if (out_data !== 16'd0 || out_ovf !== 1'b0) begin
            bad++;
            $display("FAIL len0_result got=%h/%b want=0000/0", out_data, out_ovf);
        end
        consume;
    endtask

    task automatic test_bubbles;
        fill(16'sd8192, 14'sd4);
        tv[0] = 1'b1; tv[1] = 1'b0; tv[2] = 1'b0; tv[3] = 1'b1;
        tv[4] = 1'b1; tv[5] = 1'b0; tv[6] = 1'b1;
        run_job(4);
        total++;
        if (hs_cnt !== 4) begin
            bad++;
            $display("FAIL bubble_handshakes got=%0d want=4", hs_cnt);
        end
        total++;
        if (done_cyc !== 10) begin
            bad++;
            $display("FAIL bubble_latency got=%0d want=10", done_cyc);
        end
        total++;
        if (rdy_late !== 0) begin
            bad++;
            $display("FAIL bubble_ready_after got=%0d want=0", rdy_late);
        end
        total++;
        if (out_data !== 16'd16 || out_ovf !== 1'b0) begin
            bad++;
            $display("FAIL bubble_result got=%0d/%b want=16/0", out_data, out_ovf);
        end
        consume;
    endtask

    task automatic test_hold;
        fill(-16'sd5, -14'sd8192);
        run_job(1);
        for (int i = 0; i < 10; i++) begin
            start = 1'b1;
            len = 8'd0;
            step;
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || out_data !== 16'd5 || mul_ce !== 1'b0) begin
                bad++;
                $display("FAIL hold_cycle%0d got=%b/%0d/%b want=1/5/0",
                         i, out_valid, out_data, mul_ce);
            end
        end
        step;
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'd0) begin
            bad++;
            $display("FAIL hold_release got=%b/%b/%h want=0/0/0000",
                     busy, out_valid, out_data);
        end
        step;
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || out_valid !== 1'b1 || out_data !== 16'd0) begin
            bad++;
            $display("FAIL hold_restart got=%b/%b/%h want=1/1/0000",
                     busy, out_valid, out_data);
        end
        consume;
    endtask

    task automatic test_reset_mid;
        start = 1'b1;
        len = 8'd5;
        step;
        start = 1'b0;
        in_valid = 1'b1;
        in_a = 16'sd1000;
        in_b = -14'sd8192;
        for (int c = 1; c <= 5; c++) step;
        total++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || mul_ce !== 1'b1) begin
            bad++;
            $display("FAIL drain_state got=%b/%b/%b want=1/0/1", busy, in_ready, mul_ce);
        end
        reset = 1'b1;
        in_valid = 1'b0;
        step;
        reset = 1'b0;
        total++;
        if ({busy, in_ready, mul_ce, out_valid, out_ovf} !== 5'b0 ||
            {mul_din0, mul_din1, out_data} !== 46'd0) begin
            bad++;
            $display("FAIL midreset_outputs got=%b want=00000",
                     {busy, in_ready, mul_ce, out_valid, out_ovf});
        end
        fill(-16'sd8192, -14'sd8192);
        run_job(1);
        total++;
        if (done_cyc !== 4 || out_data !== 16'd8192 || out_ovf !== 1'b0) begin
            bad++;
            $display("FAIL midreset_next_job got=%0d/%0d/%b want=4/8192/0",
                     done_cyc, out_data, out_ovf);
        end
        consume;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_overflow;
        test_floor_and_zero;
        test_bubbles;
        test_hold;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
